// File: rtl/mv_pkg.sv
// Shared types and helpers for the matrix-vector sequencer and its command interface.
package mv_pkg;

  // Sequencer states, in the order a row is processed.
  typedef enum logic [3:0] {
    IDLE,
    CLR,
    RD_X,
    WT_X,
    RD_W,
    WT_W,
    MAC,
    WR_R,
    FIN
  } state_t;

  // Element-width encoding carried on cfg_wide_i.
  localparam logic ELEM_NARROW = 1'b0;
  localparam logic ELEM_WIDE   = 1'b1;

  // Command function codes decoded by the command interface in front of this block.
  typedef enum logic [1:0] {
    CMD_NOP      = 2'd0,
    CMD_CFG_DIM  = 2'd1,
    CMD_CFG_ADDR = 2'd2,
    CMD_START    = 2'd3
  } cmd_t;

  // Byte stride between consecutive elements.
  function automatic logic [1:0] elem_size(input logic wide);
    return (wide == ELEM_WIDE) ? 2'd2 : 2'd1;
  endfunction

  // Sign-extend a raw memory word to a 16-bit MAC operand.
  function automatic logic [15:0] elem_extract(input logic [15:0] raw, input logic wide);
    return (wide == ELEM_WIDE) ? raw : {{8{raw[7]}}, raw[7:0]};
  endfunction

endpackage

// File: rtl/mv_addr_gen.sv
// Address pointers and loop counters for the row-major matrix-vector walk.
module mv_addr_gen
  import mv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              row_start,
  input  logic              step,
  input  logic              row_adv,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [ADDR_W-1:0] cfg_addr_w,
  input  logic [ADDR_W-1:0] cfg_addr_x,
  input  logic [ADDR_W-1:0] cfg_addr_r,
  input  logic              cfg_wide,
  output logic [ADDR_W-1:0] xptr,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W-1:0] rptr,
  output logic              wide,
  output logic              last_i,
  output logic              last_j
);

  localparam logic [ADDR_W-1:0] R_STEP = ADDR_W'(ACC_W / 8);

  logic [ADDR_W-1:0] xbase;
  logic [DIM_W-1:0]  m_last;
  logic [DIM_W-1:0]  n_last;
  logic [DIM_W-1:0]  i_cnt;
  logic [DIM_W-1:0]  j_cnt;
  logic [ADDR_W-1:0] esz;

  assign esz    = ADDR_W'(elem_size(wide));
  assign last_i = (i_cnt == m_last);
  assign last_j = (j_cnt == n_last);

  // Latch the config on start, then walk pointers and counters under FSM control.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      xptr   <= '0;
      wptr   <= '0;
      rptr   <= '0;
      xbase  <= '0;
      m_last <= '0;
      n_last <= '0;
      i_cnt  <= '0;
      j_cnt  <= '0;
      wide   <= ELEM_NARROW;
    end else if (load) begin
      xptr   <= cfg_addr_x;
      xbase  <= cfg_addr_x;
      wptr   <= cfg_addr_w;
      rptr   <= cfg_addr_r;
      m_last <= cfg_m - DIM_W'(1);
      n_last <= cfg_n - DIM_W'(1);
      i_cnt  <= '0;
      j_cnt  <= '0;
      wide   <= cfg_wide;
    end else begin
      if (row_start) begin
        xptr  <= xbase;
        j_cnt <= '0;
      end
      if (step) begin
        xptr <= xptr + esz;
        wptr <= wptr + esz;
        if (!last_j) j_cnt <= j_cnt + DIM_W'(1);
      end
      if (row_adv) begin
        rptr <= rptr + R_STEP;
        if (!last_i) i_cnt <= i_cnt + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/mv_seq_ctrl.sv
// Matrix-vector sequencer: fetches X[j] and W[i][j], drives the MAC, writes each row of R.
module mv_seq_ctrl
  import mv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [DIM_W-1:0]  cfg_m_i,
  input  logic [DIM_W-1:0]  cfg_n_i,
  input  logic [ADDR_W-1:0] cfg_addr_w_i,
  input  logic [ADDR_W-1:0] cfg_addr_x_i,
  input  logic [ADDR_W-1:0] cfg_addr_r_i,
  input  logic              cfg_wide_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_write_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [ACC_W-1:0]  mem_req_data_o,
  input  logic              mem_resp_valid_i,
  input  logic [15:0]       mem_resp_data_i,
  output logic              mac_clear_o,
  output logic              mac_en_o,
  output logic [15:0]       mac_x_o,
  output logic [15:0]       mac_w_o,
  input  logic [ACC_W-1:0]  mac_acc_i,
  output logic              busy_o,
  output logic              done_o
);

  state_t            state, state_nx;
  logic              load, row_start, step, row_adv;
  logic [ADDR_W-1:0] xptr, wptr, rptr;
  logic              wide, last_i, last_j;
  logic [15:0]       x_q, w_q;

  mv_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .ACC_W(ACC_W)) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .row_start  (row_start),
    .step       (step),
    .row_adv    (row_adv),
    .cfg_m      (cfg_m_i),
    .cfg_n      (cfg_n_i),
    .cfg_addr_w (cfg_addr_w_i),
    .cfg_addr_x (cfg_addr_x_i),
    .cfg_addr_r (cfg_addr_r_i),
    .cfg_wide   (cfg_wide_i),
    .xptr       (xptr),
    .wptr       (wptr),
    .rptr       (rptr),
    .wide       (wide),
    .last_i     (last_i),
    .last_j     (last_j)
  );

  assign mac_x_o = x_q;
  assign mac_w_o = w_q;

  // State register; reset aborts any run on the next edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Capture operands only while waiting for their read; stray responses elsewhere are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      w_q <= '0;
    end else begin
      if (state == WT_X && mem_resp_valid_i) x_q <= elem_extract(mem_resp_data_i, wide);
      if (state == WT_W && mem_resp_valid_i) w_q <= elem_extract(mem_resp_data_i, wide);
    end
  end

  // Next-state and output decode; request fields depend only on state and pointers, so
  // they stay put while a request waits for ready.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_nx        = state;
    start_ready_o   = 1'b0;
    busy_o          = 1'b1;
    done_o          = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_write_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_data_o  = '0;
    mac_clear_o     = 1'b0;
    mac_en_o        = 1'b0;
    load            = 1'b0;
    row_start       = 1'b0;
    step            = 1'b0;
    row_adv         = 1'b0;
    unique case (state)
      IDLE: begin
        busy_o        = 1'b0;
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          load     = 1'b1;
          state_nx = (cfg_m_i == '0 || cfg_n_i == '0) ? FIN : CLR;
        end
      end
      CLR: begin
        mac_clear_o = 1'b1;
        row_start   = 1'b1;
        state_nx    = RD_X;
      end
      RD_X: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = xptr;
        if (mem_req_ready_i) state_nx = WT_X;
      end
      WT_X: if (mem_resp_valid_i) state_nx = RD_W;
      RD_W: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = wptr;
        if (mem_req_ready_i) state_nx = WT_W;
      end
      WT_W: if (mem_resp_valid_i) state_nx = MAC;
      MAC: begin
        mac_en_o = 1'b1;
        step     = 1'b1;
        state_nx = last_j ? WR_R : RD_X;
      end
      WR_R: begin
        mem_req_valid_o = 1'b1;
        mem_req_write_o = 1'b1;
        mem_req_addr_o  = rptr;
        mem_req_data_o  = mac_acc_i;
        if (mem_req_ready_i) begin
          row_adv  = 1'b1;
          state_nx = last_i ? FIN : CLR;
        end
      end
      FIN: begin
        busy_o   = 1'b0;
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy_o   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mv_seq_ctrl.sv
// Bench for mv_seq_ctrl: transaction-level model of R = W*X plus memory and MAC responders.
module tb_mv_seq_ctrl;

  localparam int ADDR_W = 32;
  localparam int DIM_W  = 16;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_valid_i;
  logic              start_ready_o;
  logic [DIM_W-1:0]  cfg_m_i, cfg_n_i;
  logic [ADDR_W-1:0] cfg_addr_w_i, cfg_addr_x_i, cfg_addr_r_i;
  logic              cfg_wide_i;
  logic              mem_req_valid_o, mem_req_ready_i, mem_req_write_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic [ACC_W-1:0]  mem_req_data_o;
  logic              mem_resp_valid_i;
  logic [15:0]       mem_resp_data_i;
  logic              mac_clear_o, mac_en_o;
  logic [15:0]       mac_x_o, mac_w_o;
  logic [ACC_W-1:0]  mac_acc_i;
  logic              busy_o, done_o;

  always #5 clk = ~clk;

  mv_seq_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .ACC_W(ACC_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_valid_i    (start_valid_i),
    .start_ready_o    (start_ready_o),
    .cfg_m_i          (cfg_m_i),
    .cfg_n_i          (cfg_n_i),
    .cfg_addr_w_i     (cfg_addr_w_i),
    .cfg_addr_x_i     (cfg_addr_x_i),
    .cfg_addr_r_i     (cfg_addr_r_i),
    .cfg_wide_i       (cfg_wide_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_write_o  (mem_req_write_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_data_o   (mem_req_data_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .mac_clear_o      (mac_clear_o),
    .mac_en_o         (mac_en_o),
    .mac_x_o          (mac_x_o),
    .mac_w_o          (mac_w_o),
    .mac_acc_i        (mac_acc_i),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] w;
  } op_t;

  req_t        exp_req[$];
  op_t         exp_ops[$];
  logic [31:0] hs_addr[$];
  logic [15:0] mem_w[logic [31:0]];

  int  checks = 0;
  int  failures = 0;
  int  stall_cycles = 0;
  int  resp_lat = 1;
  bit  stray_en = 1'b0;
  int  n_done, n_clear, n_mac, hs_count;
  int  exp_clear_n, exp_mac_n;
  logic [15:0] first_x, first_w;
  logic [31:0] first_wdata;
  bit  wdata_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents: explicit entries, otherwise a fixed hash of the address.
  function automatic logic [15:0] word_at(input logic [31:0] a);
    logic [15:0] h;
    if (mem_w.exists(a)) return mem_w[a];
    h = 16'(a[15:0] * 16'h9E37) ^ 16'h2B5D;
    return h;
  endfunction

  function automatic logic [15:0] elem_of(input logic [15:0] raw, input logic wide);
    return wide ? raw : {{8{raw[7]}}, raw[7:0]};
  endfunction

  // Expected transactions for R = W*X with row-major W.
  task automatic build_model(input int m, input int n, input logic [31:0] aw,
                             input logic [31:0] ax, input logic [31:0] ar, input logic wide);
    logic [31:0]        esz, xa, wa;
    logic signed [31:0] acc, prod;
    req_t r;
    op_t  o;
    exp_req.delete();
    exp_ops.delete();
    esz = wide ? 32'd2 : 32'd1;
    exp_clear_n = 0;
    exp_mac_n   = 0;
    if (m != 0 && n != 0) begin
      for (int i = 0; i < m; i++) begin
        acc = 0;
        for (int j = 0; j < n; j++) begin
          xa = ax + 32'(j) * esz;
          wa = aw + (32'(i) * 32'(n) + 32'(j)) * esz;
          r.addr = xa; r.write = 1'b0; r.data = '0; exp_req.push_back(r);
          r.addr = wa; exp_req.push_back(r);
          o.x = elem_of(word_at(xa), wide);
          o.w = elem_of(word_at(wa), wide);
          exp_ops.push_back(o);
          prod = $signed(o.x) * $signed(o.w);
          acc  = acc + prod;
        end
        r.addr = ar + 32'(i) * 32'(ACC_W / 8); r.write = 1'b1; r.data = acc;
        exp_req.push_back(r);
      end
      exp_clear_n = m;
      exp_mac_n   = m * n;
    end
  endtask

  // Responders and per-cycle compare: runs on the falling edge, checks then drives.
  initial begin : mem_mac_loop
    logic [31:0]        p_addr, p_data;
    logic               p_write;
    bit                 stalled, rdy;
    int                 wait_cnt, pend;
    logic [15:0]        pend_data;
    logic signed [31:0] acc, prod;
    req_t               r;
    op_t                o;
    stalled = 0; wait_cnt = 0; pend = 0; acc = 0; pend_data = '0;
    p_addr = '0; p_data = '0; p_write = 1'b0;
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    mac_acc_i        = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0; stalled = 0; wait_cnt = 0; acc = 0;
        mem_resp_valid_i = 1'b0;
        mem_req_ready_i  = 1'b1;
        mac_acc_i        = '0;
      end else begin
        if (stalled) begin
          check("stall_valid", mem_req_valid_o, 1);
          check("stall_addr", mem_req_addr_o, p_addr);
          check("stall_write", mem_req_write_o, p_write);
          check("stall_data", mem_req_data_o, p_data);
        end else if (mem_req_valid_o) begin
          check("req_busy", busy_o, 1);
          check("req_start_ready", start_ready_o, 0);
          if (exp_req.size() == 0) begin
            check("req_unexpected", exp_req.size(), 1);
          end else begin
            r = exp_req.pop_front();
            check("req_addr", mem_req_addr_o, r.addr);
            check("req_write", mem_req_write_o, r.write);
            if (r.write) check("req_data", mem_req_data_o, r.data);
            hs_addr.push_back(mem_req_addr_o);
            if (mem_req_write_o && !wdata_seen) begin
              first_wdata = mem_req_data_o;
              wdata_seen  = 1'b1;
            end
          end
        end
        if (mac_clear_o) begin
          n_clear++;
          acc = 0;
        end
        if (mac_en_o) begin
          n_mac++;
          if (exp_ops.size() == 0) begin
            check("mac_unexpected", exp_ops.size(), 1);
          end else begin
            o = exp_ops.pop_front();
            check("mac_x", mac_x_o, o.x);
            check("mac_w", mac_w_o, o.w);
          end
          if (n_mac == 1) begin
            first_x = mac_x_o;
            first_w = mac_w_o;
          end
          prod = $signed(mac_x_o) * $signed(mac_w_o);
          acc  = acc + prod;
        end
        if (done_o) begin
          n_done++;
          check("done_busy", busy_o, 0);
          check("done_start_ready", start_ready_o, 0);
        end
        mac_acc_i = acc;

        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = 16'hC3C3;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = pend_data;
          end
        end
        if (mem_req_valid_o) begin
          if (wait_cnt < stall_cycles) begin
            rdy = 1'b0;
            wait_cnt++;
            if (stray_en && wait_cnt == 1 && !mem_req_write_o && pend == 0 && !mem_resp_valid_i) begin
              mem_resp_valid_i = 1'b1;
              mem_resp_data_i  = 16'h5A5A;
            end
          end else begin
            rdy = 1'b1;
          end
        end else begin
          rdy = (stall_cycles == 0);
        end
        mem_req_ready_i = rdy;
        if (mem_req_valid_o && rdy) begin
          hs_count++;
          wait_cnt = 0;
          if (!mem_req_write_o) begin
            pend      = resp_lat;
            pend_data = word_at(mem_req_addr_o);
          end
        end
        stalled = mem_req_valid_o && !rdy;
        p_addr  = mem_req_addr_o;
        p_write = mem_req_write_o;
        p_data  = mem_req_data_o;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, start_ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_req_valid"}, mem_req_valid_o, 0);
    check({tag, "_req_write"}, mem_req_write_o, 0);
    check({tag, "_req_addr"}, mem_req_addr_o, 0);
    check({tag, "_req_data"}, mem_req_data_o, 0);
    check({tag, "_mac_clear"}, mac_clear_o, 0);
    check({tag, "_mac_en"}, mac_en_o, 0);
    check({tag, "_mac_x"}, mac_x_o, 0);
    check({tag, "_mac_w"}, mac_w_o, 0);
  endtask

  task automatic clear_counters();
    n_done = 0; n_clear = 0; n_mac = 0; hs_count = 0;
    hs_addr.delete();
    wdata_seen = 1'b0;
    first_wdata = '0; first_x = '0; first_w = '0;
  endtask

  task automatic start_cmd(input int m, input int n, input logic [31:0] aw,
                           input logic [31:0] ax, input logic [31:0] ar, input logic wide);
    @(negedge clk);
    check("pre_start_ready", start_ready_o, 1);
    cfg_m_i = DIM_W'(m); cfg_n_i = DIM_W'(n);
    cfg_addr_w_i = aw; cfg_addr_x_i = ax; cfg_addr_r_i = ar; cfg_wide_i = wide;
    start_valid_i = 1'b1;
    @(negedge clk);
    start_valid_i = 1'b0;
    // Junk on the config bus after accept must not disturb the run.
    cfg_m_i = '1; cfg_n_i = '1; cfg_addr_w_i = '1; cfg_addr_x_i = '1; cfg_addr_r_i = '1;
    cfg_wide_i = ~wide;
  endtask

  task automatic run(input string tag, input int m, input int n, input logic [31:0] aw,
                     input logic [31:0] ax, input logic [31:0] ar, input logic wide,
                     input int stall, input int lat, input bit stray);
    int cyc;
    stall_cycles = stall; resp_lat = lat; stray_en = stray;
    build_model(m, n, aw, ax, ar, wide);
    clear_counters();
    start_cmd(m, n, aw, ax, ar, wide);
    if (m == 0 || n == 0) begin
      check({tag, "_zero_done_latency"}, done_o, 1);
      check({tag, "_zero_no_req"}, mem_req_valid_o, 0);
    end else begin
      check({tag, "_busy_after_accept"}, busy_o, 1);
    end
    cyc = 0;
    while (n_done == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, n_done, 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, n_done, 1);
    check({tag, "_reqs_left"}, exp_req.size(), 0);
    check({tag, "_ops_left"}, exp_ops.size(), 0);
    check({tag, "_clear_count"}, n_clear, exp_clear_n);
    check({tag, "_mac_count"}, n_mac, exp_mac_n);
    check({tag, "_idle_ready"}, start_ready_o, 1);
    check({tag, "_idle_busy"}, busy_o, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    reset = 1'b1;
    start_valid_i = 1'b0;
    cfg_m_i = '0; cfg_n_i = '0;
    cfg_addr_w_i = '0; cfg_addr_x_i = '0; cfg_addr_r_i = '0;
    cfg_wide_i = 1'b0;
    clear_counters();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Basic walk with pinned data: row 0 = -1*127 + 2*16 + 3*(-16) = -143.
    mem_w[32'h2000] = 16'h00FF; mem_w[32'h2001] = 16'h0002; mem_w[32'h2002] = 16'h0003;
    mem_w[32'h1000] = 16'hAB7F; mem_w[32'h1001] = 16'h0010; mem_w[32'h1002] = 16'h00F0;
    run("basic", 2, 3, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0, 1, 1'b0);
    check("basic_hs_count", hs_addr.size(), 14);
    if (hs_addr.size() >= 14) begin
      check("basic_rd0", hs_addr[0], 32'h2000);
      check("basic_rd1", hs_addr[1], 32'h1000);
      check("basic_rd2", hs_addr[2], 32'h2001);
      check("basic_rd3", hs_addr[3], 32'h1001);
      check("basic_wr0", hs_addr[6], 32'h3000);
      check("basic_row1_x", hs_addr[7], 32'h2000);
      check("basic_row1_w", hs_addr[8], 32'h1003);
      check("basic_wr1", hs_addr[13], 32'h3004);
    end
    check("basic_mac_pulses", n_mac, 6);
    check("basic_clear_pulses", n_clear, 2);
    check("sext_narrow_ff", first_x, 16'hFFFF);
    check("sext_narrow_ab7f", first_w, 16'h007F);
    check("basic_row0_sum", first_wdata, 32'hFFFF_FF71);

    // Wide elements: stride 2, full 16-bit operands.
    mem_w[32'h2000] = 16'h8001;
    run("wide", 2, 3, 32'h1000, 32'h2000, 32'h3000, 1'b1, 0, 1, 1'b0);
    if (hs_addr.size() >= 14) begin
      check("wide_w0", hs_addr[1], 32'h1000);
      check("wide_w1", hs_addr[3], 32'h1002);
      check("wide_x2", hs_addr[4], 32'h2004);
      check("wide_w_last", hs_addr[12], 32'h100A);
    end
    check("wide_x_8001", first_x, 16'h8001);

    // Backpressure on every request, longer read latency, stray responses while stalled.
    run("bp", 2, 2, 32'h1000, 32'h2000, 32'h3000, 1'b0, 5, 2, 1'b1);
    stall_cycles = 0; stray_en = 1'b0;

    // Zero dimensions finish with no memory traffic.
    run("zero_m", 0, 4, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0, 1, 1'b0);
    check("zero_m_hs", hs_count, 0);
    run("zero_n", 3, 0, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0, 1, 1'b0);
    check("zero_n_hs", hs_count, 0);

    // Pointer wrap at the top of the address space.
    run("wrap", 2, 2, 32'hFFFF_FFFE, 32'h0000_0010, 32'hFFFF_FFFC, 1'b1, 0, 1, 1'b0);
    if (hs_addr.size() >= 10) begin
      check("wrap_w1", hs_addr[3], 32'h0000_0000);
      check("wrap_wr1", hs_addr[9], 32'h0000_0000);
    end

    // Reset while waiting for the row-1 W response; the response must be dropped.
    mem_w[32'h2000] = 16'h00FF;
    stall_cycles = 0; resp_lat = 4; stray_en = 1'b0;
    build_model(2, 3, 32'h1000, 32'h2000, 32'h3000, 1'b0);
    clear_counters();
    start_cmd(2, 3, 32'h1000, 32'h2000, 32'h3000, 1'b0);
    cyc = 0;
    while (hs_count < 9 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_row1_w", hs_count, 9);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    exp_req.delete();
    exp_ops.delete();
    repeat (6) @(negedge clk);
    check("midrst_no_resume", mem_req_valid_o, 0);
    check("midrst_idle_ready", start_ready_o, 1);

    run("rerun", 2, 3, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0, 1, 1'b0);
    if (hs_addr.size() >= 2) begin
      check("rerun_rd0", hs_addr[0], 32'h2000);
      check("rerun_rd1", hs_addr[1], 32'h1000);
    end
    check("rerun_row0_sum", first_wdata, 32'hFFFF_FF71);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mv_seq_ctrl.md
Name: mv_seq_ctrl

Overview:
Sequencer for the matrix-vector accelerator. It computes R = W·X once the command interface has latched M, N, addrW, addrX, addrR and the element width. For each row it fetches X[j] and W[i][j] over a single-outstanding memory port, drives the external MAC datapath, then writes the row result to R. It sits between the command interface (config plus start) and the memory and MAC blocks.

Parameters:
ADDR_W, 32, memory address width
DIM_W, 16, width of the M/N dimension fields
ACC_W, 32, MAC accumulator width (result write width; a multiple of 8)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start_valid_i  in  1  config valid; accepted only in IDLE
start_ready_o  out  1  high only in IDLE
cfg_m_i  in  DIM_W  rows of W
cfg_n_i  in  DIM_W  columns of W / length of X
cfg_addr_w_i  in  ADDR_W  W base address (row-major)
cfg_addr_x_i  in  ADDR_W  X base address
cfg_addr_r_i  in  ADDR_W  R base address
cfg_wide_i  in  1  0 = 8-bit elements, 1 = 16-bit elements
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory request ready
mem_req_write_o  out  1  1 = write R, 0 = read
mem_req_addr_o  out  ADDR_W  request byte address
mem_req_data_o  out  ACC_W  write data (the mac_acc_i snapshot)
mem_resp_valid_i  in  1  read data valid (one per read)
mem_resp_data_i  in  16  read data; low byte only when narrow
mac_clear_o  out  1  zero the accumulator (1-cycle pulse)
mac_en_o  out  1  accumulate mac_x_o*mac_w_o this cycle
mac_x_o  out  16  sign-extended X element
mac_w_o  out  16  sign-extended W element
mac_acc_i  in  ACC_W  accumulator value; valid the cycle after mac_en_o
busy_o  out  1  high from start accept until done
done_o  out  1  1-cycle pulse at completion

Behaviour:
- Reset values: all outputs 0 except start_ready_o = 1. State is IDLE. Reset mid-operation aborts immediately with no further requests, and any pending response is dropped.
- Start handshake: start_valid_i & start_ready_o latches all cfg_* inputs. Config inputs are ignored outside IDLE.
- Zero dimension: if M==0 or N==0, go to FIN; done_o pulses 1 cycle after accept with no memory traffic.
- State IDLE: on start accept, go to CLR.
- State CLR: mac_clear_o=1 for 1 cycle; j=0 and the X pointer is reloaded to addrX. Next state is RD_X.
- State RD_X: valid=1, write=0, addr=xptr. Holds until ready, then WT_X.
- State WT_X: on resp_valid, latch the X element, then RD_W.
- State RD_W: addr=wptr. Holds until ready, then WT_W.
- State WT_W: on resp_valid, latch the W element, then MAC.
- State MAC: mac_en_o=1 for 1 cycle. xptr+=esz and wptr+=esz, with esz = 1 (narrow) or 2 (wide). If j==N-1, go to WR_R; else j++ and go to RD_X.
- State WR_R: valid=1, write=1, addr=rptr, data=mac_acc_i. Holds until ready, then rptr+=ACC_W/8. If i==M-1, go to FIN; else i++ and go to CLR.
- State FIN: done_o=1 for 1 cycle, busy_o drops, then IDLE.
- Request stability: while mem_req_valid_o is high and ready is low, addr, write and data are held stable.
- Outstanding reads: at most one read is outstanding. resp_valid outside the WT_* states is ignored. A response may arrive in the cycle after the request handshake at the earliest.
- Pointers: wptr starts at addrW and is never reset per row (row-major walk). xptr is reset per row. Additions wrap modulo 2^ADDR_W.
- Element extraction: narrow elements are sign-extended from mem_resp_data_i[7:0], wide elements use [15:0].
- Loop counters: i and j are DIM_W bits and compare against M-1 and N-1; dimensions up to 2^DIM_W-1 are supported.

Decomposition:
- Package mv_pkg: state enum (IDLE, CLR, RD_X, WT_X, RD_W, WT_W, MAC, WR_R, FIN), element-width encoding constants, and the command function codes shared with the command interface.
- Sub-module mv_addr_gen: holds xptr/wptr/rptr and the i/j counters, with load, step and row-advance controls. The FSM stays in mv_seq_ctrl.

Test Plan:
- Basic walk: M=2, N=3, narrow, addrW=0x1000, addrX=0x2000, addrR=0x3000, memory always ready, 1-cycle response.
  - Reads in order: 0x2000, 0x1000, 0x2001, 0x1001, 0x2002, 0x1002, 0x2000, 0x1003, ...
  - Writes at 0x3000 and 0x3004.
  - 6 mac_en_o pulses and 2 mac_clear_o pulses; done_o fires exactly once.
- Wide mode: same config with cfg_wide_i=1 → W reads at 0x1000, 0x1002, …, 0x100A; X reads at 0x2000, 0x2002, 0x2004. Response 0x8001 gives mac_x_o = 0x8001.
- Sign extension: narrow response 0x00FF → mac operand 0xFFFF. Response 0xAB7F → 0x007F.
- Backpressure: mem_req_ready_i low for 5 cycles on each request → addr/write/data stable throughout, no duplicate requests. A stray resp_valid in RD_X is ignored.
- Zero dimension: M=0, N=4 → no mem_req_valid_o; done_o one cycle after accept. Also M=3, N=0 gives the same.
- Reset mid-run: assert reset during WT_W of row 1 → next cycle all outputs are at reset values and start_ready_o=1. A new start runs cleanly from row 0.
